// File: rtl/seq_detect_mealy_if.sv
// Stream and status bundle for the serial pattern detector.
// master = upstream bit source / status consumer, slave = detector.
interface seq_detect_mealy_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
);
  logic             x_valid;
  logic             x;
  logic             clr_cnt;
  logic             match;
  logic [IDX_W-1:0] prog;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output x_valid, x, clr_cnt,
    input  match, prog, match_cnt, cnt_sat
  );

  modport slave (
    input  x_valid, x, clr_cnt,
    output match, prog, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detect_mealy.sv
// Parametrised Mealy serial-pattern detector with a KMP transition table built at
// elaboration, optional overlap, and a saturating match counter.
module seq_detect_mealy #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_mealy_if.slave bus
);
  localparam int IDX_W = $clog2(PATTERN_W);
  localparam int TBL_W = PATTERN_W * IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Next state for every k given input bit b: the longest proper suffix of
  // (first k pattern bits, b) that is also a pattern prefix.
  function automatic logic [TBL_W-1:0] build_tbl(input logic b);
    logic [TBL_W-1:0] tbl;
    int               best;
    int               maxlen;
    int               pos;
    logic             ok;
    logic             sbit;
    tbl = '0;
    for (int k = 0; k < PATTERN_W; k++) begin
      best   = 0;
      maxlen = (k + 1 < PATTERN_W) ? k + 1 : PATTERN_W - 1;
      for (int len = maxlen; len >= 1; len--) begin
        ok = 1'b1;
        for (int t = 0; t < len; t++) begin
          pos  = k + 1 - len + t;
          sbit = (pos == k) ? b : PATTERN[PATTERN_W-1-pos];
          if (sbit != PATTERN[PATTERN_W-1-t]) begin
            ok = 1'b0;
          end else begin
            ok = ok;
          end
        end
        if (ok && best == 0) begin
          best = len;
        end else begin
          best = best;
        end
      end
      if (k == PATTERN_W - 1 && b == PATTERN[0] && !OVERLAP) begin
        best = 0;
      end else begin
        best = best;
      end
      tbl[k*IDX_W +: IDX_W] = best[IDX_W-1:0];
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NXT0 = build_tbl(1'b0);
  localparam logic [TBL_W-1:0] NXT1 = build_tbl(1'b1);

  logic [IDX_W-1:0] state_r;
  logic [IDX_W-1:0] state_nxt_s;
  logic [IDX_W-1:0] tbl_nxt_s;
  logic             legal_s;
  logic             last_s;
  logic             exp_s;
  logic             match_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Table lookup, Mealy match and counter next value.
  always_comb begin
    tbl_nxt_s   = '0;
    legal_s     = 1'b0;
    last_s      = 1'b0;
    exp_s       = 1'b0;
    match_s     = 1'b0;
    state_nxt_s = '0;
    cnt_nxt_s   = cnt_r;
    for (int k = 0; k < PATTERN_W; k++) begin
      legal_s   = legal_s | (state_r == IDX_W'(k));
      last_s    = last_s | ((state_r == IDX_W'(k)) && (k == PATTERN_W - 1));
      exp_s     = exp_s | ((state_r == IDX_W'(k)) && PATTERN[PATTERN_W-1-k]);
      tbl_nxt_s = tbl_nxt_s | ((state_r == IDX_W'(k)) ?
                  (bus.x ? NXT1[k*IDX_W +: IDX_W] : NXT0[k*IDX_W +: IDX_W]) : '0);
    end
    // Out-of-range encodings fall back to 0 and never assert match.
    if (!legal_s) begin
      state_nxt_s = '0;
    end else if (bus.x_valid) begin
      state_nxt_s = tbl_nxt_s;
      match_s     = !rst && last_s && (bus.x == exp_s);
    end else begin
      state_nxt_s = state_r;
    end
    if (bus.clr_cnt) begin
      cnt_nxt_s = match_s ? CNT_ONE : '0;
    end else if (match_s && cnt_r != CNT_MAX) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign bus.match     = match_s;
  assign bus.prog      = state_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cnt_sat   = &cnt_r;
endmodule

// File: tb/tb_seq_detect_mealy.sv
// Lockstep bench for three detector configurations (overlap, non-overlap, 2-bit counter)
// against a history-based reference model feeding per-instance scoreboards.
module tb_seq_detect_mealy;
  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detect_mealy_if #(.IDX_W(2), .CNT_W(8)) b0 ();
  seq_detect_mealy_if #(.IDX_W(2), .CNT_W(8)) b1 ();
  seq_detect_mealy_if #(.IDX_W(2), .CNT_W(2)) b2 ();

  seq_detect_mealy #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov  (.clk(clk), .rst(rst), .bus(b0));
  seq_detect_mealy #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (.clk(clk), .rst(rst), .bus(b1));
  seq_detect_mealy #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(b2));

  typedef struct packed {
    logic       m;
    logic [1:0] p;
    logic [7:0] c;
    logic       s;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] hist  [3];
  int          nbits [3];
  int          cnt   [3];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic int cmax(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic int prog_of(input logic [31:0] h, input int nb);
    for (int l = 3; l >= 1; l--) begin
      logic [31:0] msk;
      logic [31:0] pfx;
      msk = (32'd1 << l) - 32'd1;
      pfx = 32'(PAT) >> (4 - l);
      if (l <= nb && (h & msk) == pfx) return l;
    end
    return 0;
  endfunction

  // Reference: a match is the last four valid bits equal to PAT since the last restart.
  task automatic model(input int i, input logic v, input logic xb, input logic clr,
                       input logic r, output exp_t e);
    e.m = 1'b0;
    if (r) begin
      hist[i]  = 32'd0;
      nbits[i] = 0;
      cnt[i]   = 0;
    end else begin
      if (v) begin
        hist[i] = {hist[i][30:0], xb};
        if (nbits[i] < 32) nbits[i]++;
        e.m = (nbits[i] >= 4) && (hist[i][3:0] == PAT);
        if (e.m && i == 1) nbits[i] = 0;
      end
      if (clr) cnt[i] = e.m ? 1 : 0;
      else if (e.m && cnt[i] < cmax(i)) cnt[i]++;
    end
    e.p = 2'(prog_of(hist[i], nbits[i]));
    e.c = 8'(cnt[i]);
    e.s = (cnt[i] == cmax(i));
  endtask

  task automatic step(input logic v, input logic xb, input logic clr, input logic r);
    exp_t e0;
    exp_t e1;
    exp_t e2;
    rst = r;
    b0.x_valid = v; b0.x = xb; b0.clr_cnt = clr;
    b1.x_valid = v; b1.x = xb; b1.clr_cnt = clr;
    b2.x_valid = v; b2.x = xb; b2.clr_cnt = clr;
    model(0, v, xb, clr, r, e0); q0.push_back(e0);
    model(1, v, xb, clr, r, e1); q1.push_back(e1);
    model(2, v, xb, clr, r, e2); q2.push_back(e2);
    @(negedge clk);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    check("match_ov",  32'(b0.match), 32'(e0.m));
    check("match_nov", 32'(b1.match), 32'(e1.m));
    check("match_sat", 32'(b2.match), 32'(e2.m));
    @(posedge clk);
    #1;
    check("prog_ov",   32'(b0.prog),      32'(e0.p));
    check("prog_nov",  32'(b1.prog),      32'(e1.p));
    check("prog_sat",  32'(b2.prog),      32'(e2.p));
    check("cnt_ov",    32'(b0.match_cnt), 32'(e0.c));
    check("cnt_nov",   32'(b1.match_cnt), 32'(e1.c));
    check("cnt_sat",   32'(b2.match_cnt), 32'(e2.c));
    check("sat_ov",    32'(b0.cnt_sat),   32'(e0.s));
    check("sat_nov",   32'(b1.cnt_sat),   32'(e1.s));
    check("sat_sat",   32'(b2.cnt_sat),   32'(e2.s));
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0, 1'b0);
  endtask

  task automatic rst_glitch();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    b0.x_valid = 1'b0; b0.x = 1'b0; b0.clr_cnt = 1'b0;
    b1.x_valid = 1'b0; b1.x = 1'b0; b1.clr_cnt = 1'b0;
    b2.x_valid = 1'b0; b2.x = 1'b0; b2.clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b1011, 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b1011011, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b101011, 6);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b10, 2);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(32'b11, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) send_bits(32'b1011, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rst_glitch();
    send_bits(32'b011, 3);
    repeat (300) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 40) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
